// File: rtl/ecc_pkg.sv
// Shared SECDED helpers: code geometry for a given payload width and the encoded-word layout.
package ecc_pkg;

  // Smallest r with 2^r >= data_width + r + 1 (Hamming bound).
  function automatic int get_parity_width(input int data_width);
    int r;
    r = 0;
    while ((1 << r) < data_width + r + 1) r++;
    return r;
  endfunction

  // Hamming code word plus the extended (overall) parity bit.
  function automatic int get_cw_width(input int data_width);
    return data_width + get_parity_width(data_width) + 1;
  endfunction

  function automatic logic is_pow2(input int p);
    return (p > 0) && ((p & (p - 1)) == 0);
  endfunction

  localparam int DefDataWidth = 64;
  localparam int DefCwWidth   = get_cw_width(DefDataWidth);

  // Encoder output layout: overall parity on top, position p of the code word at bit p-1.
  typedef struct packed {
    logic                  parity;
    logic [DefCwWidth-2:0] code_word;
  } ecc_word_t;

endpackage

// File: rtl/ecc_syndrome.sv
// Combinational Hamming syndrome: XOR of the 1-based positions of every set code word bit.
module ecc_syndrome #(
  parameter int CwWidth     = 72,
  parameter int ParityWidth = 7
) (
  input  logic [CwWidth-2:0]     code_word_i,
  output logic [ParityWidth-1:0] syndrome_o
);

  always_comb begin
    syndrome_o = '0;
    for (int p = 1; p < CwWidth; p++) begin
      if (code_word_i[p-1]) syndrome_o = syndrome_o ^ ParityWidth'(p);
    end
  end

endmodule

// File: rtl/ecc_decode_pipe.sv
// Two-stage SECDED decoder with valid/ready on both sides and saturating error-event counters.
module ecc_decode_pipe import ecc_pkg::*; #(
  parameter int DataWidth   = 64,
  parameter int CntWidth    = 16,
  parameter int ParityWidth = get_parity_width(DataWidth),
  parameter int CwWidth     = get_cw_width(DataWidth)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [CwWidth-1:0]     data_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [DataWidth-1:0]   data_o,
  output logic [ParityWidth-1:0] syndrome_o,
  output logic                   single_error_o,
  output logic                   double_error_o,
  input  logic                   clear_i,
  output logic [CntWidth-1:0]    single_cnt_o,
  output logic [CntWidth-1:0]    double_cnt_o
);

  typedef struct packed {
    logic               parity;
    logic [CwWidth-2:0] code_word;
  } word_t;

  word_t                  in_word;
  logic [ParityWidth-1:0] in_syn;

  assign in_word = data_i;

  ecc_syndrome #(
    .CwWidth     (CwWidth),
    .ParityWidth (ParityWidth)
  ) u_syndrome (
    .code_word_i (in_word.code_word),
    .syndrome_o  (in_syn)
  );

  // Handshake: a word moves on a cycle where valid and ready are both high; a producer holds
  // valid and its payload until then. Each stage advances when empty or when the next one does.
  logic s1_valid;
  logic s1_pm;
  logic [CwWidth-2:0]     s1_cw;
  logic [ParityWidth-1:0] s1_syn;
  logic s1_adv, s2_adv;

  assign s2_adv  = !valid_o || ready_i;
  assign s1_adv  = !s1_valid || s2_adv;
  assign ready_o = s1_adv;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_pm    <= 1'b0;
      s1_cw    <= '0;
      s1_syn   <= '0;
    end else if (s1_adv) begin
      s1_valid <= valid_i;
      if (valid_i) begin
        s1_cw  <= in_word.code_word;
        s1_syn <= in_syn;
        s1_pm  <= in_word.parity ^ (^in_word.code_word);
      end
    end
  end

  logic syn_nz, syn_in_range;
  logic fix_single, flag_single, flag_double;
  logic [CwWidth-2:0]   fixed_cw;
  logic [DataWidth-1:0] extracted;
  logic                 unused_fixed_parity;

  assign syn_nz       = |s1_syn;
  assign syn_in_range = s1_syn <= ParityWidth'(CwWidth - 1);
  assign fix_single   = syn_nz && s1_pm && syn_in_range;
  assign flag_single  = s1_pm && (!syn_nz || syn_in_range);
  assign flag_double  = syn_nz && !(s1_pm && syn_in_range);

  // Correct position s, then gather the non-power-of-two positions in ascending order.
  always_comb begin
    int k;
    k                   = 0;
    fixed_cw            = s1_cw;
    extracted           = '0;
    unused_fixed_parity = 1'b0;
    for (int p = 1; p < CwWidth; p++) begin
      if (fix_single && (s1_syn == ParityWidth'(p))) fixed_cw[p-1] = ~s1_cw[p-1];
      if (is_pow2(p)) begin
        unused_fixed_parity = unused_fixed_parity ^ fixed_cw[p-1];
      end else begin
        extracted[k] = fixed_cw[p-1];
        k++;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o        <= 1'b0;
      data_o         <= '0;
      syndrome_o     <= '0;
      single_error_o <= 1'b0;
      double_error_o <= 1'b0;
    end else if (s2_adv) begin
      valid_o <= s1_valid;
      if (s1_valid) begin
        data_o         <= extracted;
        syndrome_o     <= s1_syn;
        single_error_o <= flag_single;
        double_error_o <= flag_double;
      end
    end
  end

  logic out_hs, inc_single, inc_double;

  assign out_hs     = valid_o && ready_i;
  assign inc_single = out_hs && single_error_o;
  assign inc_double = out_hs && double_error_o;

  // A clear that coincides with an event keeps that event: load 1 instead of 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      single_cnt_o <= '0;
      double_cnt_o <= '0;
    end else begin
      if (clear_i) begin
        single_cnt_o <= CntWidth'(inc_single);
      end else if (inc_single && (single_cnt_o != {CntWidth{1'b1}})) begin
        single_cnt_o <= single_cnt_o + CntWidth'(1);
      end
      if (clear_i) begin
        double_cnt_o <= CntWidth'(inc_double);
      end else if (inc_double && (double_cnt_o != {CntWidth{1'b1}})) begin
        double_cnt_o <= double_cnt_o + CntWidth'(1);
      end
    end
  end

endmodule

// File: tb/tb_ecc_decode_pipe.sv
// Directed bench for ecc_decode_pipe (64-bit payload, 2-bit counters to reach saturation quickly).
module tb_ecc_decode_pipe;

  localparam int DW  = 64;
  localparam int CW  = 72;
  localparam int PW  = 7;
  localparam int CNT = 2;
  localparam logic [63:0] D = 64'h0123_4567_89AB_CDEF;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [CW-1:0] data_i = '0;
  logic          valid_o;
  logic          ready_i = 1'b1;
  logic [DW-1:0] data_o;
  logic [PW-1:0] syndrome_o;
  logic          single_error_o;
  logic          double_error_o;
  logic          clear_i = 1'b0;
  logic [CNT-1:0] single_cnt_o;
  logic [CNT-1:0] double_cnt_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  ecc_decode_pipe #(.DataWidth(DW), .CntWidth(CNT)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .data_i         (data_i),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .data_o         (data_o),
    .syndrome_o     (syndrome_o),
    .single_error_o (single_error_o),
    .double_error_o (double_error_o),
    .clear_i        (clear_i),
    .single_cnt_o   (single_cnt_o),
    .double_cnt_o   (double_cnt_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference encoder: data in non-power-of-two positions, Hamming parity zeroes the syndrome.
  function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
    logic [CW-2:0] cw;
    logic [PW-1:0] s;
    int k;
    cw = '0;
    k  = 0;
    for (int p = 1; p < CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = d[k];
        k++;
      end
    end
    s = '0;
    for (int p = 1; p < CW; p++) if (cw[p-1]) s = s ^ PW'(p);
    for (int i = 0; i < PW; i++) cw[(1 << i) - 1] = s[i];
    return {^cw, cw};
  endfunction

  function automatic logic [CW-1:0] flip(input logic [CW-1:0] w, input int b);
    logic [CW-1:0] one;
    one = 1;
    return w ^ (one << b);
  endfunction

  // Driver: one word through an idle pipe with ready_i=1, checking latency, result and counters.
  task automatic run_one(input string tag, input logic [CW-1:0] w, input logic [DW-1:0] ed,
                         input logic [PW-1:0] es, input logic esg, input logic edb,
                         input logic chk_data, input logic clr,
                         input logic [CNT-1:0] esc, input logic [CNT-1:0] edc);
    @(negedge clk);
    ready_i = 1'b1;
    valid_i = 1'b1;
    data_i  = w;
    #1;
    check({tag, "_ready"}, 64'(ready_o), 64'd1);
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    check({tag, "_lat1"}, 64'(valid_o), 64'd0);
    @(negedge clk);
    #1;
    check({tag, "_valid"}, 64'(valid_o), 64'd1);
    if (chk_data) check({tag, "_data"}, data_o, ed);
    check({tag, "_syn"}, 64'(syndrome_o), 64'(es));
    check({tag, "_single"}, 64'(single_error_o), 64'(esg));
    check({tag, "_double"}, 64'(double_error_o), 64'(edb));
    clear_i = clr;
    @(negedge clk);
    clear_i = 1'b0;
    #1;
    check({tag, "_drain"}, 64'(valid_o), 64'd0);
    check({tag, "_scnt"}, 64'(single_cnt_o), 64'(esc));
    check({tag, "_dcnt"}, 64'(double_cnt_o), 64'(edc));
  endtask

  // Five clean words back to back, downstream stalled on cycles 3..7.
  task automatic stream_test();
    logic [DW-1:0] pay[5];
    logic [DW-1:0] held_data;
    logic held, in_hs, out_hs;
    int sent, got;
    exp_q.delete();
    for (int i = 0; i < 5; i++) pay[i] = D ^ (64'h0101_0101_0101_0101 * 64'(i + 1));
    sent = 0;
    got  = 0;
    held = 1'b0;
    held_data = '0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clk);
      ready_i = !(c >= 3 && c <= 7);
      valid_i = (sent < 5);
      data_i  = (sent < 5) ? encode(pay[sent]) : '0;
      #1;
      if (held) begin
        check("stall_valid", 64'(valid_o), 64'd1);
        check("stall_data", data_o, held_data);
      end
      if (!ready_i && (sent - got) == 2) check("stall_ready", 64'(ready_o), 64'd0);
      in_hs  = valid_i && ready_o;
      out_hs = valid_o && ready_i;
      if (out_hs) begin
        if (exp_q.size() == 0) check("stream_spurious", 64'd1, 64'd0);
        else check("stream_order", data_o, exp_q.pop_front());
        got++;
      end
      if (in_hs) begin
        exp_q.push_back(pay[sent]);
        sent++;
      end
      held      = valid_o && !ready_i;
      held_data = data_o;
    end
    @(negedge clk);
    valid_i = 1'b0;
    ready_i = 1'b1;
    #1;
    check("stream_count", 64'(got), 64'd5);
    check("stream_left", 64'(exp_q.size()), 64'd0);
    check("stream_scnt", 64'(single_cnt_o), 64'd2);
    check("stream_dcnt", 64'(double_cnt_o), 64'd2);
  endtask

  initial begin
    logic [CW-1:0] enc;
    enc = encode(D);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_data", data_o, 64'd0);
    check("rst_syn", 64'(syndrome_o), 64'd0);
    check("rst_flags", 64'({single_error_o, double_error_o}), 64'd0);
    check("rst_cnts", 64'({single_cnt_o, double_cnt_o}), 64'd0);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    #1;
    check("rst_ready", 64'(ready_o), 64'd1);

    run_one("clean",  enc,                 D, 7'd0,   1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
    run_one("pos5",   flip(enc, 4),        D, 7'd5,   1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0);
    run_one("xpar",   flip(enc, CW - 1),   D, 7'd0,   1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 2'd0);
    run_one("dbl01",  flip(flip(enc, 0), 1), D, 7'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 2'd1);
    // Three flips at positions 64, 32, 31: odd parity but syndrome 127 is beyond the word.
    run_one("imposs", flip(flip(flip(enc, 63), 31), 30), D, 7'd127, 1'b0, 1'b1, 1'b0, 1'b0,
            2'd2, 2'd2);

    stream_test();

    // Clear alone
    @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    #1;
    check("clear_scnt", 64'(single_cnt_o), 64'd0);
    check("clear_dcnt", 64'(double_cnt_o), 64'd0);

    // Saturation with singles at data and parity positions, including the top position 71
    run_one("sat1", flip(enc, 2),  D, 7'd3,  1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0);
    run_one("sat2", flip(enc, 63), D, 7'd64, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 2'd0);
    run_one("sat3", flip(enc, 6),  D, 7'd7,  1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0);
    run_one("sat4", flip(enc, 8),  D, 7'd9,  1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0);
    run_one("sat5", flip(enc, 70), D, 7'd71, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0);
    run_one("clrinc", flip(enc, 11), D, 7'd12, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 2'd0);

    // Asynchronous reset with two words held
    @(negedge clk);
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i  = encode(D ^ 64'h5555);
    @(negedge clk);
    data_i  = encode(D ^ 64'hAAAA);
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    check("full_valid", 64'(valid_o), 64'd1);
    check("full_ready", 64'(ready_o), 64'd0);
    rst_i = 1'b1;
    #1;
    check("arst_valid", 64'(valid_o), 64'd0);
    check("arst_data", data_o, 64'd0);
    check("arst_scnt", 64'(single_cnt_o), 64'd0);
    check("arst_dcnt", 64'(double_cnt_o), 64'd0);
    @(negedge clk);
    rst_i   = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    #1;
    check("arst_ready", 64'(ready_o), 64'd1);
    check("arst_empty", 64'(valid_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
